// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand sequencer: opcode map, FSM encoding
// and default datapath sizing.
package alu_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREGS_DEF = 8;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_ADDC    = 5'd1;
  localparam logic [4:0] OP_SUBBA   = 5'd2;
  localparam logic [4:0] OP_SUBAB   = 5'd3;
  localparam logic [4:0] OP_INC     = 5'd4;
  localparam logic [4:0] OP_DEC     = 5'd5;
  localparam logic [4:0] OP_ALU_MAX = 5'd28;
  localparam logic [4:0] OP_LOAD    = 5'd29;
  localparam logic [4:0] OP_SETC    = 5'd30;
  localparam logic [4:0] OP_CLRC    = 5'd31;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two combinational read ports, one synchronous
// write port, cleared to zero by the asynchronous reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  output logic [WIDTH-1:0]         rdata_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_b
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time onto the combinational ALU: fetch operands,
// hold them for ALU_LAT cycles, capture fout, write back and respond.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// EXEC    | ALU inputs held, latency counter running down
// RESP    | result presented on rsp_*, waiting for rsp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic [$clog2(NREGS)-1:0] cmd_ra,
  input  logic [$clog2(NREGS)-1:0] cmd_rb,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(NREGS)-1:0] rsp_rd,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [4:0]               alu_fsec,
  output logic                     alu_carry,
  input  logic [WIDTH-1:0]         alu_fout
);

  localparam int IW = $clog2(NREGS);

  logic [1:0]       state;
  logic [3:0]       lat_cnt;
  logic             carry_flag;
  logic             accept;
  logic             capture;
  logic             we;
  logic [IW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state == ST_EXEC) && (lat_cnt == 4'd1);

  // LOAD writes at accept; ALU results write at the capture edge.
  always_comb begin
    we    = 1'b0;
    waddr = cmd_rd;
    wdata = cmd_data;
    if (accept && cmd_op == OP_LOAD) begin
      we = 1'b1;
    end else if (capture) begin
      we    = 1'b1;
      waddr = rsp_rd;
      wdata = alu_fout;
    end
  end

  alu_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_ra),
    .rdata_a (opa),
    .raddr_b (cmd_rb),
    .rdata_b (opb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      carry_flag <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_rd     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fsec   <= '0;
      alu_carry  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_rd <= cmd_rd;
            if (cmd_op <= OP_ALU_MAX) begin
              alu_a     <= opa;
              alu_b     <= opb;
              alu_fsec  <= cmd_op;
              alu_carry <= carry_flag;
              lat_cnt   <= 4'(ALU_LAT);
              state     <= ST_EXEC;
            end else begin
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
              if (cmd_op == OP_LOAD) begin
                rsp_data <= cmd_data;
              end else begin
                rsp_data   <= '0;
                carry_flag <= (cmd_op == OP_SETC);
              end
            end
          end
        end
        ST_EXEC: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (capture) begin
            rsp_data  <= alu_fout;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a latency-1 instance driven from a vector table
// plus hand-written sequences, and a latency-4 instance for the hold window.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, alu_carry;
  logic [4:0]  cmd_op, alu_fsec;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb, rsp_rd;
  logic [63:0] cmd_data, rsp_data, alu_a, alu_b, alu_fout;

  logic        c4_valid, c4_ready, c4_rvalid, c4_rready, c4_carry;
  logic [4:0]  c4_op, c4_fsec;
  logic [2:0]  c4_rd, c4_ra, c4_rb, c4_rrd;
  logic [63:0] c4_data, c4_rdata, c4_a, c4_b, c4_fout;
  logic        ov_en;
  logic [63:0] ov_val;

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] f, input logic c);
    case (f)
      OP_ADD:   return a + b;
      OP_ADDC:  return a + b + {63'd0, c};
      OP_SUBBA: return b - a;
      OP_SUBAB: return a - b;
      OP_INC:   return a + 64'd1;
      OP_DEC:   return a - 64'd1;
      default:  return a ^ b;
    endcase
  endfunction

  assign alu_fout = alu_model(alu_a, alu_b, alu_fsec, alu_carry);
  assign c4_fout  = ov_en ? ov_val : alu_model(c4_a, c4_b, c4_fsec, c4_carry);

  alu_op_sequencer #(.WIDTH(64), .NREGS(8), .ALU_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fsec(alu_fsec), .alu_carry(alu_carry),
    .alu_fout(alu_fout)
  );

  alu_op_sequencer #(.WIDTH(64), .NREGS(8), .ALU_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_op(c4_op),
    .cmd_rd(c4_rd), .cmd_ra(c4_ra), .cmd_rb(c4_rb), .cmd_data(c4_data),
    .rsp_valid(c4_rvalid), .rsp_ready(c4_rready), .rsp_data(c4_rdata), .rsp_rd(c4_rrd),
    .alu_a(c4_a), .alu_b(c4_b), .alu_fsec(c4_fsec), .alu_carry(c4_carry),
    .alu_fout(c4_fout)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_carry;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  rd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[18];

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [63:0] data,
                              input logic [63:0] exp_data, input logic exp_carry, input int exp_lat);
    vec_t v;
    v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.data = data;
    v.exp_data = exp_data; v.exp_carry = exp_carry; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issues one command on u0, scores the response; hold>0 withholds rsp_ready
  // for that many cycles and pulses a stray LOAD r5 inside the window.
  task automatic run_vec(input vec_t v, input int hold);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_op = v.op; cmd_rd = v.rd; cmd_ra = v.ra; cmd_rb = v.rb; cmd_data = v.data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.data = v.exp_data; e.rd = v.rd;
    sb.push_back(e);
    if (v.op <= OP_ALU_MAX) chk("alu_carry", 64'(alu_carry), 64'(v.exp_carry));
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("rsp_latency", 64'(n), 64'(v.exp_lat));
    if (!rsp_valid) begin void'(sb.pop_front()); return; end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_data", rsp_data, sb[0].data);
      chk("hold_rsp_rd", 64'(rsp_rd), 64'(sb[0].rd));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      if (k == 1) begin
        cmd_op = OP_LOAD; cmd_rd = 3'd5; cmd_data = 64'hDEAD; cmd_valid = 1'b1;
      end else if (k == 2) begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_rd", 64'(rsp_rd), 64'(e.rd));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_ready", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_after_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic c4_load(input logic [2:0] rd, input logic [63:0] data);
    @(negedge clk);
    c4_op = OP_LOAD; c4_rd = rd; c4_data = data; c4_valid = 1'b1;
    @(posedge clk); #1;
    c4_valid = 1'b0;
    chk("c4_load_valid", 64'(c4_rvalid), 64'd1);
    @(negedge clk);
    c4_rready = 1'b1;
    @(posedge clk); #1;
    c4_rready = 1'b0;
  endtask

  initial begin
    exp_t e;
    cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_ra = 0; cmd_rb = 0; cmd_data = 0; rsp_ready = 0;
    c4_valid = 0; c4_op = 0; c4_rd = 0; c4_ra = 0; c4_rb = 0; c4_data = 0; c4_rready = 0;
    ov_en = 0; ov_val = 0;

    tbl[0]  = mk(OP_LOAD,  3'd1, 3'd0, 3'd0, 64'd5, 64'd5, 1'b0, 0);
    tbl[1]  = mk(OP_LOAD,  3'd2, 3'd0, 3'd0, 64'd3, 64'd3, 1'b0, 0);
    tbl[2]  = mk(OP_SUBAB, 3'd3, 3'd1, 3'd2, 64'd0, 64'd2, 1'b0, 1);
    tbl[3]  = mk(OP_ADD,   3'd4, 3'd3, 3'd0, 64'd0, 64'd2, 1'b0, 1);
    tbl[4]  = mk(OP_LOAD,  3'd6, 3'd0, 3'd0, 64'h55, 64'h55, 1'b0, 0);
    tbl[5]  = mk(OP_SETC,  3'd6, 3'd0, 3'd0, 64'h99, 64'd0, 1'b0, 0);
    tbl[6]  = mk(OP_LOAD,  3'd1, 3'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    tbl[7]  = mk(OP_LOAD,  3'd2, 3'd0, 3'd0, 64'd0, 64'd0, 1'b0, 0);
    tbl[8]  = mk(OP_ADDC,  3'd7, 3'd1, 3'd2, 64'd0, 64'd0, 1'b1, 1);
    tbl[9]  = mk(OP_CLRC,  3'd5, 3'd0, 3'd0, 64'd0, 64'd0, 1'b0, 0);
    tbl[10] = mk(OP_ADDC,  3'd7, 3'd1, 3'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
    tbl[11] = mk(OP_ADD,   3'd5, 3'd6, 3'd2, 64'd0, 64'h55, 1'b0, 1);
    tbl[12] = mk(OP_LOAD,  3'd1, 3'd0, 3'd0, 64'd7, 64'd7, 1'b0, 0);
    tbl[13] = mk(OP_LOAD,  3'd2, 3'd0, 3'd0, 64'd10, 64'd10, 1'b0, 0);
    tbl[14] = mk(OP_SUBBA, 3'd1, 3'd1, 3'd2, 64'd0, 64'd3, 1'b0, 1);
    tbl[15] = mk(OP_ADD,   3'd4, 3'd1, 3'd0, 64'd0, 64'd3, 1'b0, 1);
    tbl[16] = mk(OP_INC,   3'd0, 3'd4, 3'd4, 64'd0, 64'd4, 1'b0, 1);
    tbl[17] = mk(OP_DEC,   3'd2, 3'd0, 3'd0, 64'd0, 64'd3, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_rd", 64'(rsp_rd), 64'd0);
    chk("reset_alu_a", alu_a, 64'd0);
    chk("reset_alu_b", alu_b, 64'd0);
    chk("reset_alu_fsec", 64'(alu_fsec), 64'd0);
    chk("reset_alu_carry", 64'(alu_carry), 64'd0);
    chk("reset_c4_ready", 64'(c4_ready), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(tbl[i], 0);

    // Backpressure: result held five cycles, stray LOAD r5 must be dropped.
    run_vec(mk(OP_LOAD, 3'd3, 3'd0, 3'd0, 64'h1234, 64'h1234, 1'b0, 0), 5);
    run_vec(mk(OP_INC, 3'd6, 3'd5, 3'd0, 64'd0, 64'h56, 1'b0, 1), 0);

    // Latency-4 instance: operands frozen, only the final fout counts.
    c4_load(3'd1, 64'd100);
    c4_load(3'd2, 64'd20);
    @(negedge clk);
    c4_op = OP_ADD; c4_rd = 3'd3; c4_ra = 3'd1; c4_rb = 3'd2; c4_valid = 1'b1;
    ov_en = 1'b1; ov_val = 64'hBAD;
    @(posedge clk); #1;
    c4_valid = 1'b0;
    e.data = 64'd120; e.rd = 3'd3;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      chk("c4_exec_valid", 64'(c4_rvalid), 64'd0);
      chk("c4_alu_a", c4_a, 64'd100);
      chk("c4_alu_b", c4_b, 64'd20);
      chk("c4_alu_fsec", 64'(c4_fsec), 64'(OP_ADD));
      if (k == 3) ov_en = 1'b0;
      @(posedge clk); #1;
    end
    chk("c4_valid_4th_edge", 64'(c4_rvalid), 64'd1);
    @(negedge clk);
    e = sb.pop_front();
    chk("c4_rsp_data", c4_rdata, e.data);
    chk("c4_rsp_rd", 64'(c4_rrd), 64'(e.rd));
    c4_rready = 1'b1;
    @(posedge clk); #1;
    c4_rready = 1'b0;
    chk("c4_idle_after", 64'(c4_ready), 64'd1);

    // Reset while a command is in EXEC, with carry set beforehand.
    run_vec(mk(OP_SETC, 3'd0, 3'd0, 3'd0, 64'd0, 64'd0, 1'b0, 0), 0);
    run_vec(mk(OP_LOAD, 3'd1, 3'd0, 3'd0, 64'd9, 64'd9, 1'b0, 0), 0);
    @(negedge clk);
    cmd_op = OP_ADD; cmd_rd = 3'd2; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("exec_busy", 64'(cmd_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      run_vec(mk(OP_ADDC, 3'(i), 3'(i), 3'(i), 64'd0, 64'd0, 1'b0, 1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
